// File: rtl/mmio_port_responder_if.sv
// Data-memory bus between the load/store datapath and the MMIO responder.
// master: MemWrite, MemRead, Address, WriteData out; ReadData, Hit in.
interface mmio_port_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output MemWrite, MemRead, Address, WriteData,
    input  ReadData, Hit
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_port_responder.sv
// MMIO responder: PortOut reg, synced PortIn, W1C edge flags, IRQ, TICK.
// Ports: clk, reset (async high), bus (slave), PortIn, PortOut, IRQ.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
  parameter int          IN_WIDTH    = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                IRQ
);

  localparam logic [2:0] R_OUT  = 3'd0;
  localparam logic [2:0] R_IN   = 3'd1;
  localparam logic [2:0] R_FLG  = 3'd2;
  localparam logic [2:0] R_MSK  = 3'd3;
  localparam logic [2:0] R_TICK = 3'd4;

  logic [31:0]         out_q, out_d;
  logic [IN_WIDTH-1:0] flags_q, flags_d;
  logic [IN_WIDTH-1:0] mask_q, mask_d;
  logic [31:0]         tick_q, tick_d;
  logic [IN_WIDTH-1:0] prev_q, prev_d;
  logic [IN_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [IN_WIDTH-1:0] sync_d [SYNC_STAGES];

  logic                hit;
  logic [2:0]          sel;
  logic                we;
  logic [IN_WIDTH-1:0] sync_last;
  logic [IN_WIDTH-1:0] rise;
  logic [IN_WIDTH-1:0] w1c;
  logic [31:0]         in_ext;
  logic [31:0]         rdata;
  logic                unused_addr;

  assign hit         = bus.Address[31:5] == BASE_ADDR[31:5];
  assign sel         = bus.Address[4:2];
  assign we          = bus.MemWrite & hit;
  assign unused_addr = ^bus.Address[1:0];
  assign sync_last   = sync_q[SYNC_STAGES-1];
  assign rise        = sync_last & ~prev_q;

  always_comb begin
    in_ext = '0;
    in_ext[IN_WIDTH-1:0] = sync_last;
  end

  always_comb begin
    sync_d[0] = PortIn;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    tick_d = tick_q + 32'd1;
    w1c    = '0;
    prev_d = sync_last;
    if (we) begin
      case (sel)
        R_OUT:   out_d  = bus.WriteData;
        R_FLG:   w1c    = bus.WriteData[IN_WIDTH-1:0];
        R_MSK:   mask_d = bus.WriteData[IN_WIDTH-1:0];
        R_TICK:  tick_d = bus.WriteData;
        default: ;
      endcase
    end
    // OR-ing new rises after the clear makes set win over clear.
    flags_d = (flags_q & ~w1c) | (rise & mask_q);
  end

  always_comb begin
    rdata = '0;
    if (bus.MemRead && hit) begin
      case (sel)
        R_OUT:   rdata = out_q;
        R_IN:    rdata = in_ext;
        R_FLG:   rdata[IN_WIDTH-1:0] = flags_q;
        R_MSK:   rdata[IN_WIDTH-1:0] = mask_q;
        R_TICK:  rdata = tick_q;
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      tick_q  <= '0;
      prev_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      tick_q  <= tick_d;
      prev_q  <= prev_d;
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_d[i];
    end
  end

  assign bus.ReadData = rdata;
  assign bus.Hit      = hit;
  assign PortOut      = out_q;
  assign IRQ          = |flags_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder.
// Drives on negedge, samples #1 after drive or after posedge.
module tb_mmio_port_responder;
  localparam logic [31:0] A_OUT  = 32'h1001_0100;
  localparam logic [31:0] A_IN   = 32'h1001_0104;
  localparam logic [31:0] A_FLG  = 32'h1001_0108;
  localparam logic [31:0] A_MSK  = 32'h1001_010C;
  localparam logic [31:0] A_TICK = 32'h1001_0110;
  localparam logic [31:0] A_RSV  = 32'h1001_0118;
  localparam logic [31:0] A_MISS = 32'h1001_0200;

  logic        clk;
  logic        reset;
  logic [7:0]  port_in;
  logic [31:0] port_out;
  logic        irq;
  int          n_cmp;
  int          n_err;

  mmio_port_responder_if bus ();

  mmio_port_responder dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PortIn  (port_in),
    .PortOut (port_out),
    .IRQ     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.Address   = a;
    bus.WriteData = d;
    @(posedge clk);
    #1;
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    @(negedge clk);
    bus.MemRead = 1'b1;
    bus.Address = a;
    #1;
    chk(tag, bus.ReadData, exp);
    bus.MemRead = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    port_in = 8'hA5;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Address   = A_OUT;
    bus.WriteData = '0;
    cyc(3);
    #1;
    chk("rst_portout", port_out, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rdata", bus.ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(3);
    rd("in_a5", A_IN, 32'h0000_00A5);
    chk("hit_in", {31'h0, bus.Hit}, 32'h1);
    rd("flg_nomask", A_FLG, 32'h0);
    chk("irq_nomask", {31'h0, irq}, 32'h0);

    wr(A_OUT, 32'hDEAD_BEEF);
    chk("portout_db", port_out, 32'hDEAD_BEEF);
    rd("rd_out", A_OUT, 32'hDEAD_BEEF);
    rd("rd_rsv", A_RSV, 32'h0);
    wr(A_RSV, 32'h1234_5678);
    rd("rd_rsv_w", A_RSV, 32'h0);

    port_in = 8'h00;
    cyc(4);
    wr(A_MSK, 32'hFFFF_FF0F);
    rd("mask_trunc", A_MSK, 32'h0000_000F);
    @(negedge clk);
    port_in = 8'h13;
    cyc(4);
    rd("flg_03", A_FLG, 32'h03);
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(A_FLG, 32'h01);
    rd("flg_w1c", A_FLG, 32'h02);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    wr(A_MSK, 32'h0);
    rd("flg_mask0", A_FLG, 32'h02);
    wr(A_MSK, 32'h0F);

    @(negedge clk);
    port_in = 8'h11;
    cyc(4);
    rd("flg_fall", A_FLG, 32'h02);
    @(negedge clk);
    port_in = 8'h13;
    cyc(2);
    wr(A_FLG, 32'h02);
    rd("flg_setwins", A_FLG, 32'h02);

    wr(A_TICK, 32'hFFFF_FFFE);
    rd("tick0", A_TICK, 32'hFFFF_FFFE);
    rd("tick1", A_TICK, 32'hFFFF_FFFF);
    rd("tick2", A_TICK, 32'h0000_0000);

    @(negedge clk);
    bus.MemRead   = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.Address   = A_OUT;
    bus.WriteData = 32'h0000_0077;
    #1;
    chk("rw_old", bus.ReadData, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    chk("rw_new", port_out, 32'h0000_0077);

    wr(A_MISS, 32'h1234_5678);
    chk("miss_out", port_out, 32'h0000_0077);
    rd("miss_rd", A_MISS, 32'h0);
    chk("miss_hit", {31'h0, bus.Hit}, 32'h0);

    wr(A_FLG, 32'hFF);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    @(negedge clk);
    port_in = 8'h12;
    cyc(4);
    @(negedge clk);
    port_in = 8'h13;
    cyc(4);
    rd("flg_01", A_FLG, 32'h01);
    wr(A_OUT, 32'h5);
    chk("out_5", port_out, 32'h5);

    @(negedge clk);
    reset = 1'b1;
    bus.MemRead = 1'b1;
    bus.Address = A_TICK;
    #1;
    chk("mid_out", port_out, 32'h0);
    chk("mid_irq", {31'h0, irq}, 32'h0);
    chk("mid_tick", bus.ReadData, 32'h0);
    bus.Address = A_IN;
    #1;
    chk("mid_in", bus.ReadData, 32'h0);
    bus.MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd("post_tick", A_TICK, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus; it is the target end of the load/store interface, sitting beside the data RAM.
- Owns the processor's external ports: drives the 32-bit PortOut register and samples the 8-bit PortIn through a synchronizer.
- Adds rising-edge capture with W1C flags, an IRQ summary line and a free-running tick counter.
- Top level uses Hit to select ReadData from this block instead of from RAM.

Parameters:
- BASE_ADDR, 32'h1001_0100, base byte address of the 32-byte register window; bits [4:0] must be 0.
- IN_WIDTH, 8, width of PortIn.
- SYNC_STAGES, 2, synchronizer depth for PortIn; legal values are 2 or 3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  store strobe from the control unit.
- MemRead  in  1  load strobe from the control unit.
- Address  in  32  byte address, taken from the ALU result.
- WriteData  in  32  store data, taken from register-file ReadData2.
- ReadData  out  32  load data (combinational).
- Hit  out  1  high when Address[31:5] == BASE_ADDR[31:5]; combinational; independent of MemRead/MemWrite.
- PortIn  in  IN_WIDTH  asynchronous external inputs.
- PortOut  out  32  output port register.
- IRQ  out  1  high when any bit of EDGE_FLAGS is set (registered-state OR).

Behaviour:
- Decode: the register is selected by word offset Address[4:2]. Address[1:0] is ignored; only whole-word access is supported.
- Register map (offsets):
  - 0x00 OUT: RW, 32 bits.
  - 0x04 IN: RO, synchronized PortIn, zero-extended.
  - 0x08 EDGE_FLAGS: W1C, IN_WIDTH bits.
  - 0x0C EDGE_MASK: RW, IN_WIDTH bits.
  - 0x10 TICK: RW, 32 bits.
  - 0x14–0x1C: reserved; read 0, writes ignored.
- Read path: combinational, so a load completes in the same cycle, matching the single-cycle datapath. ReadData = selected register when MemRead && Hit, otherwise 32'h0.
- Write path: a register updates on the rising clk edge when MemWrite && Hit. Write latency is 1 cycle, so a load in the following instruction returns the new value. Bits above IN_WIDTH are discarded on write and read back as 0.
- Simultaneous MemRead and MemWrite (illegal from the control unit): the write takes effect and the read returns the pre-write value.
- Reset values:
  - OUT = 0, EDGE_FLAGS = 0, EDGE_MASK = 0, TICK = 0.
  - All synchronizer and previous-sample flops = 0.
  - Consequences: PortOut = 0, IRQ = 0, ReadData = 0 unless reading.
- Input synchronizer: a SYNC_STAGES flop chain, followed by a prev flop.
  - IN reads the last synchronizer stage.
  - Latency from a PortIn change to IN visibility = SYNC_STAGES cycles.
- Edge detect: rise = sync_last & ~prev, evaluated each cycle. Each cycle, EDGE_FLAGS_next = (EDGE_FLAGS & ~w1c_mask) | (rise & EDGE_MASK).
  - w1c_mask = WriteData[IN_WIDTH-1:0] when EDGE_FLAGS is written, else 0.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - Masked-off edges are never recorded. Writing EDGE_MASK does not clear flags that are already set.
  - After reset, a PortIn bit held at 1 produces one rise event when it reaches the last stage, because prev resets to 0.
- IRQ: combinational OR of the EDGE_FLAGS flops; it asserts in the cycle after the flag-setting edge.
- TICK: increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
  - A write loads WriteData instead of incrementing (write wins).
  - Increment resumes on the next cycle, so a write of X followed by a read one cycle later returns X.
- Reset asserted mid-operation: all state clears immediately (asynchronous) and any in-flight store is lost. On deassertion, state resumes from reset values at the next clk edge.
- Hit outside the window: no state change. ReadData = 0 from this block; the RAM owns the access.

Test Plan:
- Reset with PortIn = 8'hA5 → PortOut = 0, IRQ = 0. Three cycles after deassert (SYNC_STAGES = 2), a read at 0x1001_0104 returns 32'h0000_00A5; EDGE_FLAGS reads 0 because the mask is 0.
- Store 32'hDEAD_BEEF to 0x1001_0100 → PortOut = DEAD_BEEF after the edge. A load of the same address returns DEAD_BEEF; a load of 0x1001_0118 returns 0.
- EDGE_MASK = 8'h0F, then PortIn 0→8'h13 → EDGE_FLAGS = 8'h03 and IRQ = 1. A W1C write of 8'h01 → flags = 8'h02 and IRQ stays 1. A W1C write of 8'h02 in the same cycle as a new bit-1 rise → bit 1 remains set.
- Store 32'hFFFF_FFFE to TICK, then read it on each of the next 3 cycles → FFFF_FFFE, FFFF_FFFF, 0000_0000 (wrap).
- Store to 0x1001_0200 (Hit = 0) → no register changes, ReadData = 0. Assert reset mid-stream after OUT = 5 and flags = 8'h01 → PortOut, IRQ and TICK read back as 0 immediately.
